// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Fetch side performs a zero-latency lookup on PCF. Execute side detects
// mispredictions, trains the table and keeps performance counters.
module branch_predictor #(
    parameter int         IDX_W       = 6,
    parameter logic [1:0] CNT_RST     = 2'b01,
    parameter logic [2:0] BT_NOBRANCH = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic [31:0] PCE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    input  logic        StallE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredCount
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    // Table storage
    logic              valid_r  [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [31:0]       target_r [ENTRIES];
    logic [1:0]        cnt_r    [ENTRIES];

    logic [31:0] branch_cnt_r;
    logic [31:0] mispred_cnt_r;

    // Fetch-side lookup signals
    logic [IDX_W-1:0] idx_f_s;
    logic [TAG_W-1:0] tag_f_s;
    logic             hit_f_s;
    logic             pred_taken_s;

    // Execute-side signals
    logic [IDX_W-1:0] idx_e_s;
    logic [TAG_W-1:0] tag_e_s;
    logic             hit_e_s;
    logic             is_branch_s;
    logic             mispredict_s;

    // Pending write to entry idx_e_s
    logic             wr_en_s;
    logic             wr_valid_s;
    logic [TAG_W-1:0] wr_tag_s;
    logic [31:0]      wr_target_s;
    logic [1:0]       wr_cnt_s;

    assign idx_f_s = PCF[IDX_W+1:2];
    assign tag_f_s = PCF[31:IDX_W+2];
    assign idx_e_s = PCE[IDX_W+1:2];
    assign tag_e_s = PCE[31:IDX_W+2];

    // Fetch lookup: hit on valid entry with matching tag, predict on counter MSB
    always_comb begin
        hit_f_s      = valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_f_s);
        pred_taken_s = hit_f_s && cnt_r[idx_f_s][1];
        if (pred_taken_s) begin
            PredTargetF = target_r[idx_f_s];
        end else begin
            PredTargetF = PCF + 32'd4;
        end
    end

    assign PredTakenF = pred_taken_s;

    // Misprediction detection and redirect PC for the instruction in EX
    always_comb begin
        is_branch_s = (BranchTypeE != BT_NOBRANCH);
        if (is_branch_s) begin
            mispredict_s = (PredTakenE != BranchE) ||
                           (BranchE && (PredTargetE != BranchTargetE));
        end else begin
            mispredict_s = PredTakenE;
        end
        if (is_branch_s && BranchE) begin
            CorrectPCE = BranchTargetE;
        end else begin
            CorrectPCE = PCE + 32'd4;
        end
    end

    assign MispredictE = mispredict_s;

    // Training decision: compute the new contents of the EX-indexed entry
    always_comb begin
        hit_e_s     = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
        wr_en_s     = 1'b0;
        wr_valid_s  = valid_r[idx_e_s];
        wr_tag_s    = tag_r[idx_e_s];
        wr_target_s = target_r[idx_e_s];
        wr_cnt_s    = cnt_r[idx_e_s];
        if (StallE) begin
            wr_en_s = 1'b0;
        end else if (is_branch_s) begin
            if (hit_e_s) begin
                wr_en_s = 1'b1;
                if (BranchE) begin
                    wr_target_s = BranchTargetE;
                    if (cnt_r[idx_e_s] == 2'b11) begin
                        wr_cnt_s = 2'b11;
                    end else begin
                        wr_cnt_s = cnt_r[idx_e_s] + 2'b01;
                    end
                end else begin
                    if (cnt_r[idx_e_s] == 2'b00) begin
                        wr_cnt_s = 2'b00;
                    end else begin
                        wr_cnt_s = cnt_r[idx_e_s] - 2'b01;
                    end
                end
            end else if (BranchE) begin
                // Allocate on taken miss, evicting whatever lives here
                wr_en_s     = 1'b1;
                wr_valid_s  = 1'b1;
                wr_tag_s    = tag_e_s;
                wr_target_s = BranchTargetE;
                wr_cnt_s    = 2'b10;
            end else begin
                wr_en_s = 1'b0;
            end
        end else if (PredTakenE && hit_e_s) begin
            // Non-branch predicted taken: drop the stale/aliased entry
            wr_en_s    = 1'b1;
            wr_valid_s = 1'b0;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table update; reset restores every entry to invalid, weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
                cnt_r[i]    <= CNT_RST;
            end
        end else if (wr_en_s) begin
            valid_r[idx_e_s]  <= wr_valid_s;
            tag_r[idx_e_s]    <= wr_tag_s;
            target_r[idx_e_s] <= wr_target_s;
            cnt_r[idx_e_s]    <= wr_cnt_s;
        end
    end

    // Performance counters, frozen while EX is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r  <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else if (!StallE) begin
            if (is_branch_s) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
            if (mispredict_s) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign BranchCount  = branch_cnt_r;
    assign MispredCount = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    logic [2:0]  BranchTypeE;
    logic        BranchE;
    logic [31:0] BranchTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        StallE;
    logic        MispredictE;
    logic [31:0] CorrectPCE;
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;

    int checks = 0;
    int failures = 0;

    localparam logic [2:0] NOBR = 3'd0;
    localparam logic [2:0] BEQ  = 3'd1;

    branch_predictor dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF),
        .PredTargetF(PredTargetF), .PCE(PCE), .BranchTypeE(BranchTypeE),
        .BranchE(BranchE), .BranchTargetE(BranchTargetE), .PredTakenE(PredTakenE),
        .PredTargetE(PredTargetE), .StallE(StallE), .MispredictE(MispredictE),
        .CorrectPCE(CorrectPCE), .BranchCount(BranchCount), .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    // Present one EX instruction (inputs change on the falling edge)
    task automatic drive_ex(input logic [31:0] pc, input logic [2:0] bt, input logic taken,
                            input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        PCE = pc; BranchTypeE = bt; BranchE = taken; BranchTargetE = tgt;
        PredTakenE = ptaken; PredTargetE = ptgt;
    endtask

    task automatic idle_ex();
        drive_ex(32'h0, NOBR, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Let one rising edge happen, then come back to the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; StallE = 1'b0; PCF = 32'h100; idle_ex();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL reset_pred got=%0b exp=0", PredTakenF); end
        checks++; if (PredTargetF !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=104", PredTargetF); end
        checks++; if (MispredictE !== 1'b0) begin failures++; $display("FAIL reset_mispred got=%0b exp=0", MispredictE); end
        checks++; if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_taken_alloc();
        PCF = 32'h100;
        drive_ex(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        checks++; if (MispredictE !== 1'b1 || CorrectPCE !== 32'h80) begin failures++; $display("FAIL alloc_mispred got=%0b/%h exp=1/80", MispredictE, CorrectPCE); end
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL alloc_rbw got=%0b exp=0", PredTakenF); end
        step(); idle_ex(); #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin failures++; $display("FAIL alloc_lookup got=%0b/%h exp=1/80", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd1 || MispredCount !== 32'd1) begin failures++; $display("FAIL alloc_counts got=%0d/%0d exp=1/1", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        PCF = 32'h100;
        // cnt 2 -> 1: predicted taken, resolves not taken
        drive_ex(32'h100, BEQ, 1'b0, 32'h80, 1'b1, 32'h80); #1;
        checks++; if (MispredictE !== 1'b1 || CorrectPCE !== 32'h104) begin failures++; $display("FAIL nt1_mispred got=%0b/%h exp=1/104", MispredictE, CorrectPCE); end
        step(); #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin failures++; $display("FAIL nt1_lookup got=%0b/%h exp=0/104", PredTakenF, PredTargetF); end
        // cnt 1 -> 0, then 0 stays 0
        drive_ex(32'h100, BEQ, 1'b0, 32'h80, 1'b0, 32'h104); #1;
        checks++; if (MispredictE !== 1'b0) begin failures++; $display("FAIL nt2_mispred got=%0b exp=0", MispredictE); end
        step();
        step();
        // taken from 0 -> 1 keeps predicting not-taken (no wrap to 3)
        drive_ex(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104);
        step(); #1;
        checks++; if (PredTakenF !== 1'b0) begin failures++; $display("FAIL sat_low got=%0b exp=0", PredTakenF); end
        step(); idle_ex(); #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin failures++; $display("FAIL sat_recover got=%0b/%h exp=1/80", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd6 || MispredCount !== 32'd4) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=6/4", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_target_mispredict();
        PCF = 32'h100;
        drive_ex(32'h100, BEQ, 1'b1, 32'h90, 1'b1, 32'h80); #1;
        checks++; if (MispredictE !== 1'b1 || CorrectPCE !== 32'h90) begin failures++; $display("FAIL tgt_mispred got=%0b/%h exp=1/90", MispredictE, CorrectPCE); end
        step(); idle_ex(); #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h90) begin failures++; $display("FAIL tgt_update got=%0b/%h exp=1/90", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd7 || MispredCount !== 32'd5) begin failures++; $display("FAIL tgt_counts got=%0d/%0d exp=7/5", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        drive_ex(32'h100, BEQ, 1'b1, 32'h90, 1'b0, 32'h104);
        StallE = 1'b1;
        #1;
        checks++; if (MispredictE !== 1'b1) begin failures++; $display("FAIL stall_mispred got=%0b exp=1", MispredictE); end
        repeat (3) step();
        #1;
        checks++; if (BranchCount !== 32'd7 || MispredCount !== 32'd5) begin failures++; $display("FAIL stall_hold got=%0d/%0d exp=7/5", BranchCount, MispredCount); end
        StallE = 1'b0;
        step(); idle_ex(); #1;
        checks++; if (BranchCount !== 32'd8 || MispredCount !== 32'd6) begin failures++; $display("FAIL stall_once got=%0d/%0d exp=8/6", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_alias();
        drive_ex(32'h200, BEQ, 1'b1, 32'h300, 1'b0, 32'h204);
        step(); idle_ex();
        PCF = 32'h100; #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin failures++; $display("FAIL alias_evict got=%0b/%h exp=0/104", PredTakenF, PredTargetF); end
        PCF = 32'h200; #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin failures++; $display("FAIL alias_new got=%0b/%h exp=1/300", PredTakenF, PredTargetF); end
        @(negedge clk);
    endtask

    task automatic test_nobranch_inval();
        PCF = 32'h200;
        drive_ex(32'h200, NOBR, 1'b0, 32'h0, 1'b1, 32'h300); #1;
        checks++; if (MispredictE !== 1'b1 || CorrectPCE !== 32'h204) begin failures++; $display("FAIL nobr_mispred got=%0b/%h exp=1/204", MispredictE, CorrectPCE); end
        step(); idle_ex(); #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h204) begin failures++; $display("FAIL nobr_inval got=%0b/%h exp=0/204", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd9 || MispredCount !== 32'd8) begin failures++; $display("FAIL nobr_counts got=%0d/%0d exp=9/8", BranchCount, MispredCount); end
        // Not-taken miss must not allocate
        drive_ex(32'h104, BEQ, 1'b0, 32'h40, 1'b0, 32'h108);
        step(); idle_ex();
        PCF = 32'h104; #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h108) begin failures++; $display("FAIL nt_noalloc got=%0b/%h exp=0/108", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd10 || MispredCount !== 32'd8) begin failures++; $display("FAIL nt_counts got=%0d/%0d exp=10/8", BranchCount, MispredCount); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_ex(32'h100, BEQ, 1'b1, 32'h80, 1'b0, 32'h104);
        step();
        PCF = 32'h100; #1;
        checks++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin failures++; $display("FAIL rmid_pre got=%0b/%h exp=1/80", PredTakenF, PredTargetF); end
        // Async reset while a taken branch is still presented in EX
        #1 rst = 1'b1;
        #1;
        checks++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin failures++; $display("FAIL rmid_lookup got=%0b/%h exp=0/104", PredTakenF, PredTargetF); end
        checks++; if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin failures++; $display("FAIL rmid_counts got=%0d/%0d exp=0/0", BranchCount, MispredCount); end
        @(negedge clk);
        rst = 1'b0; idle_ex();
        step(); #1;
        checks++; if (PredTakenF !== 1'b0 || BranchCount !== 32'd0) begin failures++; $display("FAIL rmid_after got=%0b/%0d exp=0/0", PredTakenF, BranchCount); end
    endtask

    initial begin
        test_reset();
        test_taken_alloc();
        test_saturate();
        test_target_mispredict();
        test_stall();
        test_alias();
        test_nobranch_inval();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the RISC-V pipeline CPU; the fetch-side counterpart of the EX-stage branch decision.
- In IF it looks up PCF in a direct-mapped BTB with 2-bit saturating counters and supplies a predicted next-PC.
- In EX it takes the resolved outcome (BranchE, BranchTargetE), trains the table and flags mispredictions so hazard logic can flush IF/ID and redirect fetch.
- It also keeps branch and mispredict counters for the performance CSRs.

Parameters:
- IDX_W, 6, index width; table holds 2**IDX_W entries.
- CNT_RST, 2'b01, counter value written into every entry on reset (weakly not-taken).

Ports:
- clk  input  1  CPU clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCF  input  32  fetch PC.
- PredTakenF  output  1  prediction for PCF.
- PredTargetF  output  32  predicted target for PCF; PCF+4 when PredTakenF=0.
- PCE  input  32  PC of the instruction in EX.
- BranchTypeE  input  3  branch type of the EX instruction; encodings (BEQ..BGEU, NOBRANCH) from Parameters.v.
- BranchE  input  1  resolved taken flag from EX.
- BranchTargetE  input  32  resolved branch target.
- PredTakenE  input  1  PredTakenF carried down the pipeline to EX.
- PredTargetE  input  32  PredTargetF carried down the pipeline to EX.
- StallE  input  1  EX stalled; blocks training and counting.
- MispredictE  output  1  redirect fetch and flush younger instructions.
- CorrectPCE  output  32  PC to fetch next when MispredictE=1.
- BranchCount  output  32  resolved conditional branches.
- MispredCount  output  32  mispredictions.

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], cnt[1:0]. Index = PC[IDX_W+1:2].
- Lookup is combinational, zero latency:
  - hit = valid && tag match;
  - PredTakenF = hit && cnt[1];
  - PredTargetF = PredTakenF ? target : PCF+4.
- Reset (async, any time, including mid-update): all valid=0, all cnt=CNT_RST, targets and tags 0, both counters 0. Outputs then read PredTakenF=0, PredTargetF=PCF+4, MispredictE=0. The first edge after rst deasserts is a normal edge.
- Misprediction detection (combinational, EX):
  - Conditional branch (BranchTypeE != NOBRANCH): MispredictE = (PredTakenE != BranchE) || (BranchE && PredTargetE != BranchTargetE).
  - Non-branch (BranchTypeE == NOBRANCH): MispredictE = PredTakenE. This case is aliasing or a stale entry.
  - CorrectPCE = (BranchTypeE != NOBRANCH && BranchE) ? BranchTargetE : PCE+4.
  - MispredictE is reported regardless of StallE; the hazard unit qualifies it.
- Training happens at the rising edge when StallE=0, on entry e = index(PCE).
  - Branch, hit: cnt saturating +1 if BranchE, else saturating −1 (3 stays 3, 0 stays 0). If BranchE, target := BranchTargetE.
  - Branch, miss, BranchE=1: allocate, replacing any occupant: valid=1, tag, target := BranchTargetE, cnt := 2'b10.
  - Branch, miss, BranchE=0: no change (no allocation on not-taken).
  - NOBRANCH with PredTakenE=1: valid := 0 for e, if the tag matches PCE.
  - NOBRANCH otherwise: no change.
- Counters, at the edge when StallE=0:
  - BranchCount +1 per conditional branch;
  - MispredCount +1 per cycle with MispredictE=1;
  - both wrap modulo 2**32.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (read-before-write). The new value is visible from the next cycle.
- StallE=1: table and counters hold; repeated presentation of the same EX instruction trains exactly once, when StallE falls.

Test Plan:
- Reset, then PCF=0x100 → PredTakenF=0, PredTargetF=0x104. Assert rst mid-run with entries valid → all lookups miss on the same cycle.
- Taken BEQ at PCE=0x100, target 0x80, PredTakenE=0 → MispredictE=1, CorrectPCE=0x80; next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x80, counts 1/1.
- Same branch resolved not-taken three times from cnt=2 → cnt 1, 0, 0 (saturates). PredTakenF goes 0 after the first. The first not-taken gives MispredictE=1 with CorrectPCE=0x104.
- Predicted taken to 0x80 but resolves taken to 0x90 → MispredictE=1, CorrectPCE=0x90, stored target becomes 0x90.
- NOBRANCH at PCE=0x200 with PredTakenE=1 → MispredictE=1, CorrectPCE=0x204, entry invalidated. StallE=1 for 3 cycles on a branch → counters increment once.
- Alias test with IDX_W=6: PCs 0x100 and 0x200 share an index; a taken 0x200 evicts 0x100 → lookup of 0x100 misses.
